// File: rtl/mem_responder.sv
// mem_responder: wait-stated 64-bit memory slave with byte strobes and alignment/range error response.
module mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HTRANS,
  input  logic [63:0] PADDR,
  input  logic        HWRITE,
  input  logic [63:0] PDATA,
  input  logic [7:0]  PSTRB,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
  localparam logic [3:0] WLOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic          write_q, err_q;
  logic [63:0]   wdata_q, hold_q;
  logic [7:0]    strb_q;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   off;
  logic          err_d, accept, unused_off;
  // Subtraction keeps the upper-bound test free of BASE_ADDR+SPAN overflow.
  assign off        = PADDR - BASE_ADDR;
  assign err_d      = (PADDR[2:0] != 3'd0) || (PADDR < BASE_ADDR) || (off >= SPAN);
  assign accept     = HTRANS && (state_q != BUSY);
  assign unused_off = ^{off[63:AW+3], off[2:0]};
  assign HREADY     = state_q != BUSY;
  assign HRESP      = (state_q == DONE) && err_q;
  // Reads use the array directly in DONE so a write committed on the entering edge is visible.
  assign HRDATA     = (state_q != DONE) ? hold_q : err_q ? 64'd0 : write_q ? hold_q : mem[idx_q];
  always_ff @(posedge HCLK or negedge HRESET)
    if (!HRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 64'd0;
      strb_q  <= 8'd0;
      hold_q  <= 64'd0;
    end else begin
      if (state_q == DONE) hold_q <= HRDATA;
      if (accept) begin
        idx_q   <= off[AW+2:3];
        write_q <= HWRITE;
        err_q   <= err_d;
        wdata_q <= PDATA;
        strb_q  <= PSTRB;
        cnt_q   <= WLOAD;
        state_q <= (WAIT_CYCLES == 0) ? DONE : BUSY;
      end else if (state_q == BUSY) begin
        if (cnt_q == 4'd0) state_q <= DONE;
        else cnt_q <= cnt_q - 4'd1;
      end else state_q <= IDLE;
    end
  always_ff @(posedge HCLK)
    if (state_q == DONE && write_q && !err_q)
      for (int i = 0; i < 8; i++)
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
endmodule
